// File: rtl/sha_mem_arbiter_if.sv
// sha_mem_arbiter_if: the bus between the SHA core array, the arbiter and the
// shared synchronous-read memory port.
//
// Handshake: req[i] is core i's "valid" and gnt[i] is its "ready". A beat
// (one transfer) happens in every cycle where req[i] & gnt[i] are both high.
// While req[i] is high and gnt[i] is low the core is stalled and must hold
// req_we/req_addr/req_wdata stable. The core keeps req[i] high for the whole
// burst and drops it to release the port. Read data for a read beat in cycle t
// is returned in cycle t+1 on rdata, qualified by rvalid[i].
interface sha_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      mem_clk;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_write_data;
  logic [DATA_W-1:0]         mem_read_data;
  // Debug view of the arbiter FSM: 0 = IDLE, 1 = OWN.
  logic                      arb_state;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_read_data,
    output gnt, rvalid, rdata, busy, mem_clk, mem_we, mem_addr,
           mem_write_data, arb_state
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_read_data,
    input  gnt, rvalid, rdata, busy, mem_clk, mem_we, mem_addr,
           mem_write_data, arb_state
  );
endinterface

// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter: round-robin arbiter sharing one synchronous-read memory
// port between NUM_REQ SHA-256 hash cores.
// Optional feature macro: SHA_ARB_BURST_LIMIT_EN. When defined, an owner that
// has done MAX_BURST consecutive beats is forced off the port if another core
// is waiting. When undefined, a grant lasts until the owner drops req.
module sha_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  sha_mem_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sha_mem_arbiter: NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 2 || (MAX_BURST & (MAX_BURST - 1)) != 0) begin : g_bad_max_burst
    $error("sha_mem_arbiter: MAX_BURST must be a power of 2, at least 2");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;     // last owner; equals current owner in OWN
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;     // last address driven to memory
  logic [DATA_W-1:0]  wdata_q, wdata_d;   // last write data driven to memory

  logic               beat;
  logic [NUM_REQ-1:0] cand_req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               own_we;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;

`ifdef SHA_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST);
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
`endif

  // The owner is the only grant bit, so a beat is any granted core requesting.
  assign beat = |(gnt_q & bus.req);

  // The current owner never competes against itself; in IDLE gnt_q is zero.
  assign cand_req = bus.req & ~gnt_q;

  // Round-robin search: first requester after last_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && cand_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

  // Grant FSM: next state, next grant and round-robin pointer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
`ifdef SHA_ARB_BURST_LIMIT_EN
    beat_cnt_d = beat_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = OWN;
          last_d  = win_idx;
          gnt_d   = win_onehot;
`ifdef SHA_ARB_BURST_LIMIT_EN
          beat_cnt_d = '0;
`endif
        end
      end
      OWN: begin
        if (!beat) begin
          // Owner released: hand straight over, or fall back to IDLE.
          if (win_found) begin
            last_d = win_idx;
            gnt_d  = win_onehot;
`ifdef SHA_ARB_BURST_LIMIT_EN
            beat_cnt_d = '0;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef SHA_ARB_BURST_LIMIT_EN
        else if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
          // Burst limit reached: preempt only if someone else is waiting.
          beat_cnt_d = '0;
          if (win_found) begin
            last_d = win_idx;
            gnt_d  = win_onehot;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Memory mux: forward the owner's fields during a beat, otherwise hold.
  always_comb begin
    own_we    = bus.req_we[last_q];
    own_addr  = bus.req_addr[int'(last_q)*ADDR_W +: ADDR_W];
    own_wdata = bus.req_wdata[int'(last_q)*DATA_W +: DATA_W];
    addr_d    = beat ? own_addr  : addr_q;
    wdata_d   = beat ? own_wdata : wdata_q;
    rvalid_d  = gnt_q & bus.req & ~bus.req_we;
  end

  // State, grant, read-valid and held memory fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef SHA_ARB_BURST_LIMIT_EN
  // Beats taken by the current owner within its burst window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`endif

  assign bus.gnt            = gnt_q;
  assign bus.busy           = |gnt_q;
  assign bus.rvalid         = rvalid_q;
  assign bus.rdata          = bus.mem_read_data;
  assign bus.mem_clk        = clk;
  assign bus.mem_we         = beat & own_we;
  assign bus.mem_addr       = addr_d;
  assign bus.mem_write_data = wdata_d;
  assign bus.arb_state      = state_q;
endmodule
